// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector
//   Broadcasts one ACE snoop request to a set of cache ports, collects their
//   CR responses and merges them. Line data is forwarded from the
//   lowest-index port that reports DataTransfer; any other port reporting
//   DataTransfer has its CD beats drained and discarded.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   req_*                      incoming snoop request (addr, arsnoop, port mask)
//   ac_valid_o/ac_ready_i      per-port AC handshake; ac_addr_o/ac_snoop_o shared
//   cr_valid_i/cr_ready_o      per-port CR handshake; cr_resp_i 5 bits per port
//   cd_valid_i/cd_ready_o      per-port CD handshake; cd_data_i, cd_last_i per port
//   rsp_valid_o/rsp_ready_i    merged response (rsp_resp_o)
//   rsp_data_*                 forwarded line data from the selected source port
//   timeout_o                  one-cycle pulse when a transaction is abandoned
//
// Configuration
//   ACE_SNOOP_TIMEOUT_EN : when defined, SNOOP/DATA are bounded by
//   TIMEOUT_CYCLES; on expiry the transaction is forced to RESP with the
//   Error bit set. When undefined, the wait is unbounded and timeout_o is 0.

module ace_snoop_collector #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [3:0]                    req_snoop_i,
  input  logic [NUM_PORTS-1:0]          req_mask_i,
  output logic [NUM_PORTS-1:0]          ac_valid_o,
  input  logic [NUM_PORTS-1:0]          ac_ready_i,
  output logic [ADDR_WIDTH-1:0]         ac_addr_o,
  output logic [3:0]                    ac_snoop_o,
  input  logic [NUM_PORTS-1:0]          cr_valid_i,
  output logic [NUM_PORTS-1:0]          cr_ready_o,
  input  logic [5*NUM_PORTS-1:0]        cr_resp_i,
  input  logic [NUM_PORTS-1:0]          cd_valid_i,
  output logic [NUM_PORTS-1:0]          cd_ready_o,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0] cd_data_i,
  input  logic [NUM_PORTS-1:0]          cd_last_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [4:0]                    rsp_resp_o,
  output logic                          rsp_data_valid_o,
  input  logic                          rsp_data_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_last_o,
  output logic                          timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [NUM_PORTS-1:0]   ac_pend_q, ac_pend_d;   // AC still to be accepted
  logic [NUM_PORTS-1:0]   cr_pend_q, cr_pend_d;   // CR still to be received
  logic [NUM_PORTS-1:0]   dt_q, dt_d;             // ports that reported DataTransfer
  logic [NUM_PORTS-1:0]   cd_pend_q, cd_pend_d;   // DataTransfer ports awaiting last beat
  logic [4:0]             resp_q, resp_d;
  logic [NUM_PORTS-1:0]   src_oh;
  logic [NUM_PORTS-1:0]   ac_hs, cr_hs;
  logic                   timeout_hit;

  // Lowest set bit of dt_q; dt_q is frozen during DATA so the source never
  // moves even after its own last beat has gone.
  assign src_oh = dt_q & (~dt_q + NUM_PORTS'(1));

`ifdef ACE_SNOOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = ((state_q == ST_SNOOP) || (state_q == ST_DATA)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ST_SNOOP || state_q == ST_DATA) && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign timeout_o  = timeout_hit;
  assign ac_addr_o  = addr_q;
  assign ac_snoop_o = snoop_q;
  assign rsp_resp_o = resp_q;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    snoop_d          = snoop_q;
    ac_pend_d        = ac_pend_q;
    cr_pend_d        = cr_pend_q;
    dt_d             = dt_q;
    cd_pend_d        = cd_pend_q;
    resp_d           = resp_q;
    req_ready_o      = 1'b0;
    ac_valid_o       = '0;
    cr_ready_o       = '0;
    cd_ready_o       = '0;
    rsp_valid_o      = 1'b0;
    rsp_data_valid_o = 1'b0;
    rsp_data_o       = '0;
    rsp_last_o       = 1'b0;
    ac_hs            = '0;
    cr_hs            = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          snoop_d   = req_snoop_i;
          ac_pend_d = req_mask_i;
          cr_pend_d = req_mask_i;
          dt_d      = '0;
          cd_pend_d = '0;
          resp_d    = '0;
          state_d   = (req_mask_i != '0) ? ST_SNOOP : ST_RESP;
        end
      end

      ST_SNOOP: begin
        if (timeout_hit) begin
          ac_pend_d = '0;
          cr_pend_d = '0;
          cd_pend_d = '0;
          resp_d    = resp_q | 5'b00010;
          state_d   = ST_RESP;
        end else begin
          ac_valid_o = ac_pend_q;
          ac_hs      = ac_pend_q & ac_ready_i;
          // CR may be taken once AC is done, including in the AC handshake cycle.
          cr_ready_o = cr_pend_q & ~(ac_pend_q & ~ac_ready_i);
          cr_hs      = cr_ready_o & cr_valid_i;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (cr_hs[i]) begin
              resp_d = resp_d | cr_resp_i[5*i +: 5];
              if (cr_resp_i[5*i]) dt_d[i] = 1'b1;
            end
          end
          ac_pend_d = ac_pend_q & ~ac_hs;
          cr_pend_d = cr_pend_q & ~cr_hs;
          cd_pend_d = dt_d;
          if (ac_pend_d == '0 && cr_pend_d == '0) begin
            state_d = (dt_d != '0) ? ST_DATA : ST_RESP;
          end
        end
      end

      ST_DATA: begin
        if (timeout_hit) begin
          cd_pend_d = '0;
          resp_d    = resp_q | 5'b00010;
          state_d   = ST_RESP;
        end else begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (cd_pend_q[i]) begin
              if (src_oh[i]) begin
                cd_ready_o[i]    = rsp_data_ready_i;
                rsp_data_valid_o = cd_valid_i[i];
                rsp_data_o       = cd_data_i[DATA_WIDTH*i +: DATA_WIDTH];
                rsp_last_o       = cd_last_i[i];
              end else begin
                cd_ready_o[i] = 1'b1;  // drain and discard
              end
              if (cd_ready_o[i] && cd_valid_i[i] && cd_last_i[i]) cd_pend_d[i] = 1'b0;
            end
          end
          if (cd_pend_d == '0) state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      dt_q      <= '0;
      cd_pend_q <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      dt_q      <= dt_d;
      cd_pend_q <= cd_pend_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Directed testbench for ace_snoop_collector (NUM_PORTS=2).
// Cycle 0 is the cycle in which the request handshake happens.

module tb_ace_snoop_collector;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr_i;
  logic [3:0]      req_snoop_i;
  logic [NP-1:0]   req_mask_i;
  logic [NP-1:0]   ac_valid_o;
  logic [NP-1:0]   ac_ready_i;
  logic [AW-1:0]   ac_addr_o;
  logic [3:0]      ac_snoop_o;
  logic [NP-1:0]   cr_valid_i;
  logic [NP-1:0]   cr_ready_o;
  logic [5*NP-1:0] cr_resp_i;
  logic [NP-1:0]   cd_valid_i;
  logic [NP-1:0]   cd_ready_o;
  logic [DW*NP-1:0] cd_data_i;
  logic [NP-1:0]   cd_last_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [4:0]      rsp_resp_o;
  logic            rsp_data_valid_o;
  logic            rsp_data_ready_i;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_last_o;
  logic            timeout_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  ace_snoop_collector #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_snoop_i(req_snoop_i), .req_mask_i(req_mask_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
    .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_resp_o(rsp_resp_o),
    .rsp_data_valid_o(rsp_data_valid_o), .rsp_data_ready_i(rsp_data_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
    .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid_i = 1'b0; req_addr_i = '0; req_snoop_i = '0; req_mask_i = '0;
    ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
    cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0;
    rsp_ready_i = 1'b0; rsp_data_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    tick(); tick();
    checks++;
    if (req_ready_o !== 1'b1 || ac_valid_o !== 2'b00 || cr_ready_o !== 2'b00 ||
        cd_ready_o !== 2'b00 || rsp_valid_o !== 1'b0 || rsp_data_valid_o !== 1'b0 ||
        rsp_resp_o !== 5'd0 || timeout_o !== 1'b0 || ac_addr_o !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b acv=%b crr=%b cdr=%b rv=%b rdv=%b resp=%b to=%b want rdy=1 rest 0",
               req_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o,
               rsp_data_valid_o, rsp_resp_o, timeout_o);
    end
    rst_i = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  // Both ports answer IsShared in the AC cycle; no data.
  task automatic test_shared_both();
    req_valid_i = 1'b1; req_mask_i = 2'b11;
    req_addr_i = 64'h0000_1234_5678_9AC0; req_snoop_i = 4'h1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++; $display("FAIL shared_req_ready: got %b want 1", req_ready_o);
    end
    tick();  // cycle 1
    clear_inputs();
    ac_ready_i = 2'b11; cr_valid_i = 2'b11; cr_resp_i = {5'b01000, 5'b01000};
    #1;
    checks++;
    if (ac_valid_o !== 2'b11 || cr_ready_o !== 2'b11 || ac_addr_o !== 64'h0000_1234_5678_9AC0 ||
        ac_snoop_o !== 4'h1 || req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL shared_snoop: acv=%b crr=%b addr=%h snp=%h rdy=%b want 11 11 000012345678 9ac0 1 0",
               ac_valid_o, cr_ready_o, ac_addr_o, ac_snoop_o, req_ready_o);
    end
    tick();  // cycle 2
    clear_inputs();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'b01000 || rsp_data_valid_o !== 1'b0 ||
        ac_valid_o !== 2'b00) begin
      failures++;
      $display("FAIL shared_resp: rv=%b resp=%b rdv=%b acv=%b want 1 01000 0 00",
               rsp_valid_o, rsp_resp_o, rsp_data_valid_o, ac_valid_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL shared_idle: rdy=%b rv=%b want 1 0", req_ready_o, rsp_valid_o);
    end
    $display("test_shared_both done");
  endtask

  // Port 1 supplies two data beats; port 0 only reports IsShared.
  task automatic test_data_single();
    req_valid_i = 1'b1; req_mask_i = 2'b11; req_addr_i = 64'h40; req_snoop_i = 4'h0;
    tick();  // cycle 1
    clear_inputs();
    ac_ready_i = 2'b11; cr_valid_i = 2'b11; cr_resp_i = {5'b00101, 5'b01000};
    tick();  // cycle 2: DATA
    clear_inputs();
    rsp_data_ready_i = 1'b1; cd_valid_i = 2'b10;
    cd_data_i[127:64] = 64'hA; cd_data_i[63:0] = 64'h77; cd_last_i = 2'b00;
    #1;
    checks++;
    if (rsp_data_valid_o !== 1'b1 || rsp_data_o !== 64'hA || rsp_last_o !== 1'b0 ||
        cd_ready_o !== 2'b10 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_beat0: rdv=%b data=%h last=%b cdr=%b rv=%b want 1 a 0 10 0",
               rsp_data_valid_o, rsp_data_o, rsp_last_o, cd_ready_o, rsp_valid_o);
    end
    tick();  // cycle 3
    cd_data_i[127:64] = 64'hB; cd_last_i = 2'b10;
    #1;
    checks++;
    if (rsp_data_valid_o !== 1'b1 || rsp_data_o !== 64'hB || rsp_last_o !== 1'b1) begin
      failures++;
      $display("FAIL single_beat1: rdv=%b data=%h last=%b want 1 b 1",
               rsp_data_valid_o, rsp_data_o, rsp_last_o);
    end
    tick();  // cycle 4: RESP
    clear_inputs();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'b01101 || rsp_data_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: rv=%b resp=%b rdv=%b want 1 01101 0",
               rsp_valid_o, rsp_resp_o, rsp_data_valid_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_data_single done");
  endtask

  // Both ports transfer data: port 0 forwarded, port 1 drained.
  task automatic test_data_both();
    req_valid_i = 1'b1; req_mask_i = 2'b11; req_addr_i = 64'h80; req_snoop_i = 4'h7;
    tick();  // cycle 1
    clear_inputs();
    ac_ready_i = 2'b11; cr_valid_i = 2'b11; cr_resp_i = {5'b00001, 5'b00001};
    tick();  // cycle 2: DATA, output stalled
    clear_inputs();
    rsp_data_ready_i = 1'b0; cd_valid_i = 2'b11;
    cd_data_i[63:0] = 64'h1; cd_data_i[127:64] = 64'h2; cd_last_i = 2'b01;
    #1;
    checks++;
    if (rsp_data_valid_o !== 1'b1 || rsp_data_o !== 64'h1 || rsp_last_o !== 1'b1 ||
        cd_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL both_stall: rdv=%b data=%h last=%b cdr=%b want 1 1 1 10",
               rsp_data_valid_o, rsp_data_o, rsp_last_o, cd_ready_o);
    end
    tick();  // cycle 3
    rsp_data_ready_i = 1'b1; cd_last_i = 2'b11;
    #1;
    checks++;
    if (cd_ready_o !== 2'b11 || rsp_data_o !== 64'h1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL both_go: cdr=%b data=%h rv=%b want 11 1 0", cd_ready_o, rsp_data_o, rsp_valid_o);
    end
    tick();  // cycle 4: RESP
    clear_inputs();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'b00001 || cd_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL both_resp: rv=%b resp=%b cdr=%b want 1 00001 00", rsp_valid_o, rsp_resp_o, cd_ready_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_data_both done");
  endtask

  task automatic test_mask_zero();
    req_valid_i = 1'b1; req_mask_i = 2'b00; req_addr_i = 64'hC0;
    tick();  // cycle 1
    clear_inputs();
    #1;
    checks++;
    if (ac_valid_o !== 2'b00 || rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'd0 || req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero: acv=%b rv=%b resp=%b rdy=%b want 00 1 00000 0",
               ac_valid_o, rsp_valid_o, rsp_resp_o, req_ready_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_mask_zero done");
  endtask

  // Single port: CR gated until AC accepted, then AC/CR in separate cycles.
  task automatic test_cr_gating();
    req_valid_i = 1'b1; req_mask_i = 2'b01; req_addr_i = 64'h100;
    tick();  // cycle 1: AC stalled, CR offered early
    clear_inputs();
    cr_valid_i = 2'b01; cr_resp_i = {5'b00000, 5'b10000};
    #1;
    checks++;
    if (ac_valid_o !== 2'b01 || cr_ready_o !== 2'b00) begin
      failures++; $display("FAIL gate_early: acv=%b crr=%b want 01 00", ac_valid_o, cr_ready_o);
    end
    tick();  // cycle 2: AC accepted, no CR yet
    cr_valid_i = 2'b00; ac_ready_i = 2'b01;
    #1;
    checks++;
    if (cr_ready_o !== 2'b01) begin
      failures++; $display("FAIL gate_same: crr=%b want 01", cr_ready_o);
    end
    tick();  // cycle 3: CR after AC
    ac_ready_i = 2'b00; cr_valid_i = 2'b01;
    #1;
    checks++;
    if (ac_valid_o !== 2'b00 || cr_ready_o !== 2'b01 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL gate_late: acv=%b crr=%b to=%b want 00 01 0", ac_valid_o, cr_ready_o, timeout_o);
    end
    tick();  // cycle 4
    clear_inputs();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'b10000) begin
      failures++; $display("FAIL gate_resp: rv=%b resp=%b want 1 10000", rsp_valid_o, rsp_resp_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_cr_gating done");
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_mask_i = 2'b11; req_addr_i = 64'h140;
    tick();
    clear_inputs();
    ac_ready_i = 2'b11; cr_valid_i = 2'b11; cr_resp_i = {5'b00000, 5'b00001};
    tick();  // DATA
    clear_inputs();
    cd_valid_i = 2'b01; cd_data_i[63:0] = 64'h55; cd_last_i = 2'b01;
    #1;
    checks++;
    if (rsp_data_valid_o !== 1'b1) begin
      failures++; $display("FAIL mid_in_data: rdv=%b want 1", rsp_data_valid_o);
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (rsp_data_valid_o !== 1'b0 || req_ready_o !== 1'b1 || cd_ready_o !== 2'b00 ||
        ac_valid_o !== 2'b00 || rsp_valid_o !== 1'b0 || rsp_resp_o !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: rdv=%b rdy=%b cdr=%b acv=%b rv=%b resp=%b want 0 1 00 00 0 0",
               rsp_data_valid_o, req_ready_o, cd_ready_o, ac_valid_o, rsp_valid_o, rsp_resp_o);
    end
    clear_inputs();
    tick();
    rst_i = 1'b0;
    tick();
    req_valid_i = 1'b1; req_mask_i = 2'b01; req_addr_i = 64'h180;
    tick();
    clear_inputs();
    ac_ready_i = 2'b01; cr_valid_i = 2'b01; cr_resp_i = {5'b00000, 5'b01000};
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_resp_o !== 5'b01000 || rsp_data_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: rv=%b resp=%b rdv=%b want 1 01000 0", rsp_valid_o, rsp_resp_o, rsp_data_valid_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_reset_mid done");
  endtask

`ifdef ACE_SNOOP_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    req_valid_i = 1'b1; req_mask_i = 2'b01; req_addr_i = 64'h1C0;
    tick();  // cycle 1
    clear_inputs();
    for (int c = 1; c <= TO; c++) begin
      if (timeout_o !== 1'b0 || ac_valid_o !== 2'b01) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL timeout_early: bad cycles=%0d want 0", early);
    end
    // cycle 17
    checks++;
    if (timeout_o !== 1'b1 || ac_valid_o !== 2'b00 || cr_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL timeout_pulse: to=%b acv=%b crr=%b want 1 00 00", timeout_o, ac_valid_o, cr_ready_o);
    end
    tick();  // cycle 18
    checks++;
    if (timeout_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_resp_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_resp: to=%b rv=%b resp=%b want 0 1 xxx1x", timeout_o, rsp_valid_o, rsp_resp_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    $display("test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_shared_both();
    test_data_single();
    test_data_both();
    test_mask_zero();
    test_cr_gating();
    test_reset_mid();
`ifdef ACE_SNOOP_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
